// File: rtl/fifo_drain_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_drain_arbiter
//
// Round-robin drain scheduler. Several first-word-fall-through channel FIFOs
// share one downstream stream. One channel is granted at a time. Up to
// BURST_LEN words are popped from it, and then the scheduler re-arbitrates.
// Channels that report half_full are served ahead of channels that are merely
// non-empty.
//
// Ports
//   clk         clock, rising edge
//   rst         asynchronous reset, active high
//   en          arbitration enable (gates only the decision taken in IDLE)
//   chn_nempty  per-FIFO not-empty flag
//   chn_half    per-FIFO half-full flag
//   chn_data    concatenated FIFO heads; channel i is [i*DATA_WIDTH +: DATA_WIDTH]
//   chn_re      per-FIFO pop strobe, one-hot or zero
//   out_data    head word of the granted channel
//   out_valid   out_data is valid
//   out_ready   consumer accepts out_data this cycle
//   out_chn     index of the granted channel
//   busy        a burst is open
//   burst_done  one-cycle pulse when a burst closes
//   dbg_state   current FSM state (0 IDLE, 1 BURST, 2 CLOSE)
//
// Handshake: a word transfers in every cycle where out_valid and out_ready
// are both high. In that same cycle the granted FIFO is popped, because
// chn_re is combinational from out_ready. While out_ready is low, out_valid,
// out_data and out_chn hold. out_valid never drops without a transfer while
// the burst is open.
// ---------------------------------------------------------------------------
module fifo_drain_arbiter #(
   parameter int NUM_CHN    = 4,
   parameter int CHN_BITS   = 2,
   parameter int DATA_WIDTH = 16,
   parameter int BURST_LEN  = 8,
   parameter int CNT_BITS   = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          en,
   input  logic [NUM_CHN-1:0]            chn_nempty,
   input  logic [NUM_CHN-1:0]            chn_half,
   input  logic [NUM_CHN*DATA_WIDTH-1:0] chn_data,
   output logic [NUM_CHN-1:0]            chn_re,
   output logic [DATA_WIDTH-1:0]         out_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [CHN_BITS-1:0]           out_chn,
   output logic                          busy,
   output logic                          burst_done,
   output logic [1:0]                    dbg_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      CLOSE = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [CHN_BITS-1:0]   chn_q, chn_d;
   logic [CHN_BITS-1:0]   last_q, last_d;
   logic [CNT_BITS-1:0]   cnt_q, cnt_d;

   logic [NUM_CHN-1:0]    cand;
   logic [CHN_BITS-1:0]   win;
   logic [CHN_BITS-1:0]   rr_idx;
   logic                  found;
   logic [CNT_BITS-1:0]   cnt_inc;
   logic                  pop;

   // Candidate set: half-full channels win if there are any. Otherwise every
   // non-empty channel competes. The scan starts one past the last grant.
   always_comb begin
      cand   = ((chn_nempty & chn_half) != '0) ? (chn_nempty & chn_half) : chn_nempty;
      win    = '0;
      rr_idx = '0;
      found  = 1'b0;
      for (int k = 0; k < NUM_CHN; k++) begin
         rr_idx = CHN_BITS'((int'(last_q) + 1 + k) % NUM_CHN);
         if (!found && cand[rr_idx]) begin
            win   = rr_idx;
            found = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         chn_q   <= '0;
         last_q  <= CHN_BITS'(NUM_CHN - 1);
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         chn_q   <= chn_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   assign cnt_inc = cnt_q + CNT_BITS'(1);

   always_comb begin
      state_d    = state_q;
      chn_d      = chn_q;
      last_d     = last_q;
      cnt_d      = cnt_q;
      chn_re     = '0;
      out_valid  = 1'b0;
      burst_done = 1'b0;
      pop        = 1'b0;
      case (state_q)
         IDLE: begin
            if (en && (chn_nempty != '0)) begin
               chn_d   = win;
               cnt_d   = '0;
               state_d = BURST;
            end
         end
         BURST: begin
            out_valid      = chn_nempty[chn_q];
            pop            = out_valid & out_ready;
            chn_re[chn_q]  = pop;
            if (pop) begin
               cnt_d = cnt_inc;
               if (cnt_inc == CNT_BITS'(BURST_LEN)) begin
                  state_d = CLOSE;
               end
            end else if (!chn_nempty[chn_q]) begin
               // The flag is registered in the FIFO, so a low nempty here is
               // the first cycle after the granted FIFO drained.
               state_d = CLOSE;
            end
         end
         CLOSE: begin
            last_d     = chn_q;
            burst_done = 1'b1;
            state_d    = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign out_data  = chn_data[int'(chn_q) * DATA_WIDTH +: DATA_WIDTH];
   assign out_chn   = chn_q;
   assign busy      = (state_q == BURST);
   assign dbg_state = state_q;

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// ---------------------------------------------------------------------------
// Bench for fifo_drain_arbiter.
//
// Each channel FIFO is a queue. Its flags and head word are refreshed after
// every clock edge, so the flags look registered to the DUT. After each load,
// a reference scheduler works out the whole drain order from the FIFO
// occupancies. It pushes the expected (channel, word) pops into exp_q. The
// monitor pops exp_q on every observed transfer.
// ---------------------------------------------------------------------------
module tb_fifo_drain_arbiter;

   localparam int NUM_CHN  = 4;
   localparam int CHN_BITS = 2;
   localparam int DW       = 16;
   localparam int BL       = 8;
   localparam int CNT_BITS = 8;
   localparam int HALF_TH  = 6;
   localparam int EW       = CHN_BITS + DW;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic                   en = 1'b0;
   logic                   out_ready = 1'b0;
   logic [NUM_CHN-1:0]     chn_nempty = '0;
   logic [NUM_CHN-1:0]     chn_half = '0;
   logic [NUM_CHN*DW-1:0]  chn_data = '0;
   logic [NUM_CHN-1:0]     chn_re;
   logic [DW-1:0]          out_data;
   logic                   out_valid;
   logic [CHN_BITS-1:0]    out_chn;
   logic                   busy;
   logic                   burst_done;
   logic [1:0]             dbg_state;

   fifo_drain_arbiter #(
      .NUM_CHN(NUM_CHN), .CHN_BITS(CHN_BITS), .DATA_WIDTH(DW),
      .BURST_LEN(BL), .CNT_BITS(CNT_BITS)
   ) dut (
      .clk(clk), .rst(rst), .en(en),
      .chn_nempty(chn_nempty), .chn_half(chn_half), .chn_data(chn_data),
      .chn_re(chn_re), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_chn(out_chn), .busy(busy),
      .burst_done(burst_done), .dbg_state(dbg_state)
   );

   // ---------------- shared state ----------------
   logic [DW-1:0]      fq [NUM_CHN][$];
   logic [EW-1:0]      exp_q [$];
   int                 gaps [$];
   int                 n_cmp = 0;
   int                 n_err = 0;
   int                 cyc = 0;
   int                 pop_total = 0;
   int                 first_pop_cyc = -1;
   int                 last_pop_cyc = -1;
   int                 bd_cnt = 0;
   int                 exp_bursts = 0;
   int                 m_last = NUM_CHN - 1;
   int                 seq = 0;
   logic [NUM_CHN-1:0] re_seen = '0;
   logic               prev_stall = 1'b0;
   logic [DW-1:0]      prev_data = '0;
   logic [CHN_BITS-1:0] prev_chn = '0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // ---------------- FIFO models ----------------
   task automatic refresh();
      for (int i = 0; i < NUM_CHN; i++) begin
         chn_nempty[i] = (fq[i].size() > 0);
         chn_half[i]   = (fq[i].size() >= HALF_TH);
         chn_data[i*DW +: DW] = (fq[i].size() > 0) ? fq[i][0] : '0;
      end
   endtask

   task automatic load(input int ch, input int n);
      for (int j = 0; j < n; j++) begin
         fq[ch].push_back(DW'((ch << 12) | (seq & 'hfff)));
         seq++;
      end
      refresh();
   endtask

   function automatic bit all_empty();
      for (int i = 0; i < NUM_CHN; i++)
         if (fq[i].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   // A pop strobe seen before an edge removes the head after the edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < NUM_CHN; i++)
            if (re_seen[i] && fq[i].size() > 0) void'(fq[i].pop_front());
         re_seen = '0;
         refresh();
      end
   end

   // ---------------- reference scheduler ----------------
   // Repeatedly pick a channel by the rules (half-full first, rotate from
   // last grant), take min(BL, occupancy) words, and update the last grant.
   task automatic model_schedule();
      int cnt [NUM_CHN];
      int ptr [NUM_CHN];
      bit ne  [NUM_CHN];
      bit hf  [NUM_CHN];
      bit any_ne, any_hf, more;
      int w, n, c;
      for (int i = 0; i < NUM_CHN; i++) begin
         cnt[i] = fq[i].size();
         ptr[i] = 0;
      end
      more = 1'b1;
      while (more) begin
         any_ne = 1'b0;
         any_hf = 1'b0;
         for (int i = 0; i < NUM_CHN; i++) begin
            ne[i] = (cnt[i] > 0);
            hf[i] = (cnt[i] >= HALF_TH);
            if (ne[i]) any_ne = 1'b1;
            if (ne[i] && hf[i]) any_hf = 1'b1;
         end
         if (!any_ne) begin
            more = 1'b0;
         end else begin
            w = -1;
            for (int k = 1; k <= NUM_CHN; k++) begin
               c = (m_last + k) % NUM_CHN;
               if (w < 0 && ne[c] && (!any_hf || hf[c])) w = c;
            end
            n = (cnt[w] < BL) ? cnt[w] : BL;
            for (int j = 0; j < n; j++)
               exp_q.push_back({CHN_BITS'(w), fq[w][ptr[w] + j]});
            ptr[w] += n;
            cnt[w] -= n;
            m_last = w;
            exp_bursts++;
         end
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   initial begin
      logic [EW-1:0]       e;
      logic [NUM_CHN-1:0]  er;
      forever begin
         @(negedge clk);
         #3;
         cyc++;
         if (rst) begin
            re_seen    = '0;
            prev_stall = 1'b0;
         end else begin
            re_seen = chn_re;
            if (burst_done) bd_cnt++;
            if (prev_stall) begin
               chk("hold_valid", 32'(out_valid), 32'd1);
               chk("hold_data", 32'(out_data), 32'(prev_data));
               chk("hold_chn", 32'(out_chn), 32'(prev_chn));
            end
            if (chn_re != '0) begin
               chk("pop_handshake", 32'({out_valid, out_ready}), 32'd3);
               if (exp_q.size() == 0) begin
                  chk("unexpected_pop", 32'(chn_re), 32'd0);
               end else begin
                  e  = exp_q.pop_front();
                  er = '0;
                  er[e[EW-1 -: CHN_BITS]] = 1'b1;
                  chk("pop_re", 32'(chn_re), 32'(er));
                  chk("pop_chn", 32'(out_chn), 32'(e[EW-1 -: CHN_BITS]));
                  chk("pop_data", 32'(out_data), 32'(e[DW-1:0]));
               end
               if (last_pop_cyc >= 0 && cyc - last_pop_cyc > 1) gaps.push_back(cyc - last_pop_cyc);
               if (first_pop_cyc < 0) first_pop_cyc = cyc;
               last_pop_cyc = cyc;
               pop_total++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_chn   = out_chn;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic start_scenario();
      exp_bursts    = 0;
      bd_cnt        = 0;
      pop_total     = 0;
      first_pop_cyc = -1;
      last_pop_cyc  = -1;
      gaps.delete();
   endtask

   // mode 0: ready always high, 1: toggle every cycle, 2: random (75% high)
   task automatic drain(input int mode, input string nm);
      int t;
      bit done;
      t = 0;
      done = 1'b0;
      while (!done && t < 3000) begin
         @(negedge clk);
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = !out_ready;
            default: out_ready = ($urandom_range(0, 3) != 0);
         endcase
         t++;
         if (exp_q.size() == 0 && all_empty() && !busy) done = 1'b1;
      end
      chk({nm, "_drained"}, 32'(done), 32'd1);
      repeat (3) @(negedge clk);
      chk({nm, "_bursts"}, 32'(bd_cnt), 32'(exp_bursts));
      chk({nm, "_leftover"}, 32'(exp_q.size()), 32'd0);
      if (!done) begin
         exp_q.delete();
         for (int i = 0; i < NUM_CHN; i++) fq[i].delete();
         refresh();
      end
      out_ready = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int t;
      int viol;
      refresh();

      // Reset with every FIFO holding one word.
      rst = 1'b1;
      en = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < NUM_CHN; i++) load(i, 1);
      repeat (3) @(negedge clk);
      #1;
      chk("rst_re", 32'(chn_re), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_chn", 32'(out_chn), 32'd0);
      chk("rst_done", 32'(burst_done), 32'd0);
      chk("rst_data", 32'(out_data), 32'(fq[0][0]));
      start_scenario();
      m_last = NUM_CHN - 1;
      model_schedule();
      @(negedge clk);
      rst = 1'b0;
      #2;
      chk("grant_c1_busy", 32'(busy), 32'd0);
      @(negedge clk);
      #2;
      chk("grant_c2_busy", 32'(busy), 32'd1);
      chk("grant_c2_valid", 32'(out_valid), 32'd1);
      chk("grant_c2_chn", 32'(out_chn), 32'd0);
      drain(0, "reset_rr");

      // Round robin across 0, 1, 3.
      start_scenario();
      load(0, 3); load(1, 3); load(3, 3);
      model_schedule();
      drain(0, "round_robin");
      chk("rr_pops", 32'(pop_total), 32'd9);

      // One channel with a long queue: bursts 8, 8, 4 with 2 idle cycles between.
      start_scenario();
      load(2, 20);
      model_schedule();
      drain(0, "long_burst");
      chk("long_pops", 32'(pop_total), 32'd20);
      chk("long_gap_count", 32'(gaps.size()), 32'd2);
      foreach (gaps[g]) chk("long_gap_len", 32'(gaps[g]), 32'd3);

      // Half-full priority: move last grant to 0, then 1 (not half) vs 3 (half).
      start_scenario();
      load(0, 1);
      model_schedule();
      drain(0, "prio_setup");
      start_scenario();
      load(1, 2); load(3, HALF_TH);
      model_schedule();
      drain(0, "half_prio");

      // Backpressure: ready toggles each cycle through an 8-word burst.
      start_scenario();
      load(1, 8);
      model_schedule();
      out_ready = 1'b0;
      drain(1, "backpressure");
      chk("bp_pops", 32'(pop_total), 32'd8);
      chk("bp_span", 32'(last_pop_cyc - first_pop_cyc + 1), 32'd15);

      // Enable dropped mid-burst: the burst finishes, then nothing is granted.
      start_scenario();
      load(0, 8); load(2, 8);
      model_schedule();
      t = 0;
      while (pop_total < 1 && t < 50) begin @(negedge clk); out_ready = 1'b1; t++; end
      en = 1'b0;
      t = 0;
      while (busy && t < 50) begin @(negedge clk); t++; end
      chk("en_burst_closed", 32'(busy), 32'd0);
      viol = 0;
      repeat (20) begin
         @(negedge clk);
         #2;
         if (chn_re != '0 || busy) viol++;
      end
      chk("en_low_no_grant", 32'(viol), 32'd0);
      chk("en_low_pops", 32'(pop_total), 32'd8);
      chk("en_low_bursts", 32'(bd_cnt), 32'd1);
      en = 1'b1;
      drain(0, "en_resume");

      // Reset after three pops: strobe dies at once, five words remain.
      start_scenario();
      load(1, 8);
      model_schedule();
      t = 0;
      while (pop_total < 3 && t < 50) begin @(negedge clk); out_ready = 1'b1; t++; end
      rst = 1'b1;
      #1;
      chk("rst_mid_re", 32'(chn_re), 32'd0);
      chk("rst_mid_valid", 32'(out_valid), 32'd0);
      chk("rst_mid_busy", 32'(busy), 32'd0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      chk("rst_mid_left", 32'(fq[1].size()), 32'd5);
      start_scenario();
      m_last = NUM_CHN - 1;
      model_schedule();
      rst = 1'b0;
      drain(0, "rst_resume");

      // Randomized loads with random backpressure.
      for (int r = 0; r < 12; r++) begin
         start_scenario();
         for (int i = 0; i < NUM_CHN; i++) load(i, $urandom_range(0, 20));
         model_schedule();
         drain(2, "random");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
